// File: rtl/perceptron_train_scheduler_if.sv
// Resolved-branch record handshake between the branch resolution unit (master)
// and the perceptron training scheduler (slave).
interface perceptron_train_scheduler_if #(
  parameter int HIST_LEN = 62,
  parameter int INDEX    = 6,
  parameter int SUM_W    = 16
);
  logic                res_valid;
  logic                res_ready;
  logic [INDEX-1:0]    res_index;
  logic [HIST_LEN-1:0] res_history;
  logic                res_outcome;
  logic                res_prediction;
  logic [SUM_W-1:0]    res_sum;

  modport master (
    output res_valid, res_index, res_history, res_outcome, res_prediction, res_sum,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_index, res_history, res_outcome, res_prediction, res_sum,
    output res_ready
  );
endinterface

// File: rtl/perceptron_train_scheduler.sv
// Perceptron weight training scheduler: filters resolved branches, queues the rest and
// performs a serial read-modify-write per record on the shared single-port weight table.
module perceptron_train_scheduler #(
  parameter int HIST_LEN  = 62,
  parameter int WIDTH     = 8,
  parameter int INDEX     = 6,
  parameter int THRESHOLD = 134,
  parameter int QDEPTH    = 4,
  parameter int SUM_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  perceptron_train_scheduler_if.slave   res,
  input  logic                          pred_req,
  input  logic [INDEX-1:0]              pred_addr,
  output logic [(HIST_LEN+1)*WIDTH-1:0] pred_rdata,
  output logic                          tbl_en,
  output logic                          tbl_we,
  output logic [INDEX-1:0]              tbl_addr,
  output logic [(HIST_LEN+1)*WIDTH-1:0] tbl_wdata,
  input  logic [(HIST_LEN+1)*WIDTH-1:0] tbl_rdata,
  output logic                          busy,
  output logic [15:0]                   train_count,
  output logic [15:0]                   skip_count
);
  localparam int ROW_W = (HIST_LEN+1)*WIDTH;
  localparam int PTR_W = $clog2(QDEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;

  localparam logic signed [SUM_W-1:0] THR_POS = SUM_W'(THRESHOLD);
  localparam logic signed [SUM_W-1:0] THR_NEG = -THR_POS;
  localparam logic [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]          state_q, state_d;
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [15:0]         train_count_q, train_count_d;
  logic [15:0]         skip_count_q, skip_count_d;
  logic [INDEX-1:0]    q_index_q [QDEPTH];
  logic [INDEX-1:0]    q_index_d [QDEPTH];
  logic [HIST_LEN-1:0] q_hist_q  [QDEPTH];
  logic [HIST_LEN-1:0] q_hist_d  [QDEPTH];
  logic                q_out_q   [QDEPTH];
  logic                q_out_d   [QDEPTH];

  logic                full, train, accept, push, skip, pop;
  logic                rd_issue, wr_issue;
  logic [INDEX-1:0]    head_index;
  logic [HIST_LEN-1:0] head_hist;
  logic                head_out;
  logic [ROW_W-1:0]    upd_row;
  logic signed [SUM_W-1:0] sum_s;

  function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] w, input logic up);
    if (up) sat_step = (w == W_MAX) ? w : w + WIDTH'(1);
    else    sat_step = (w == W_MIN) ? w : w - WIDTH'(1);
  endfunction

  // full is purely registered, so a pop frees a slot only from the next cycle on
  assign full          = (count_q == (PTR_W+1)'(QDEPTH));
  assign res.res_ready = !full;
  assign sum_s         = $signed(res.res_sum);

  always_comb begin
    train  = (res.res_outcome != res.res_prediction) || ((sum_s >= THR_NEG) && (sum_s <= THR_POS));
    accept = res.res_valid && !full;
    push   = accept && train;
    skip   = accept && !train;
  end

  assign head_index = q_index_q[head_q];
  assign head_hist  = q_hist_q[head_q];
  assign head_out   = q_out_q[head_q];

  always_comb begin
    upd_row = '0;
    upd_row[WIDTH-1:0] = sat_step(tbl_rdata[WIDTH-1:0], head_out);
    for (int unsigned j = 1; j <= HIST_LEN; j++)
      upd_row[j*WIDTH +: WIDTH] = sat_step(tbl_rdata[j*WIDTH +: WIDTH], head_out == head_hist[j-1]);
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    rd_issue = 1'b0;
    wr_issue = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0 && !pred_req) begin
          rd_issue = 1'b1;
          state_d  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        row_d   = upd_row;
        state_d = WRITE;
      end
      WRITE: begin
        if (!pred_req) begin
          wr_issue = 1'b1;
          pop      = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    head_d        = head_q + PTR_W'(pop);
    tail_d        = tail_q + PTR_W'(push);
    count_d       = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    train_count_d = train_count_q + 16'(pop);
    skip_count_d  = skip_count_q + 16'(skip);
    q_index_d     = q_index_q;
    q_hist_d      = q_hist_q;
    q_out_d       = q_out_q;
    if (push) begin
      q_index_d[tail_q] = res.res_index;
      q_hist_d[tail_q]  = res.res_history;
      q_out_d[tail_q]   = res.res_outcome;
    end
  end

  // Lookups always win the port; scheduler strobes are suppressed during reset
  always_comb begin
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = row_q;
    if (pred_req) begin
      tbl_en   = 1'b1;
      tbl_addr = pred_addr;
    end else if (!rst && rd_issue) begin
      tbl_en   = 1'b1;
      tbl_addr = head_index;
    end else if (!rst && wr_issue) begin
      tbl_en   = 1'b1;
      tbl_we   = 1'b1;
      tbl_addr = head_index;
    end
  end

  assign pred_rdata  = tbl_rdata;
  assign busy        = (count_q != '0) || (state_q != IDLE);
  assign train_count = train_count_q;
  assign skip_count  = skip_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      row_q         <= '0;
      train_count_q <= '0;
      skip_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      row_q         <= row_d;
      train_count_q <= train_count_d;
      skip_count_q  <= skip_count_d;
    end
  end

  always_ff @(posedge clk) begin
    q_index_q <= q_index_d;
    q_hist_q  <= q_hist_d;
    q_out_q   <= q_out_d;
  end
endmodule
